// File: rtl/qif_pkg.sv
// Shared types and helpers for the QIF neuron scheduler.
// Optional feature macro: QIF_REFRACTORY_EN (per-neuron refractory counters).
package qif_pkg;

    // Scheduler FSM states; exposed on the scheduler's dbg_state port.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        UPDATE = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } qif_state_e;

    // Default membrane/bias width.
    localparam int QIF_VW = 8;

    // Clamp a signed value into the unsigned range [0, hi].
    function automatic int sat_clamp(input int value, input int hi);
        if (value < 0) begin
            return 0;
        end else if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/qif_update.sv
// Shared QIF membrane-update datapath (purely combinational).
// V_next = sat(V + ((V*V) >> SQ_SHIFT) + B - LEAK), fire = V_next >= V_THRESH.
// Used under both settings of QIF_REFRACTORY_EN; refractory handling lives in the scheduler.
module qif_update
    import qif_pkg::*;
#(
    parameter int            VW       = QIF_VW,
    parameter int            SQ_SHIFT = 6,
    parameter logic [VW-1:0] V_THRESH = 8'd200,
    parameter logic [VW-1:0] LEAK     = 8'd1
) (
    input  logic [VW-1:0] v_i,
    input  logic [VW-1:0] b_i,
    output logic [VW-1:0] v_next_o,
    output logic          fire_o
);

    // Sum carries VW+2 magnitude bits plus a sign bit so the underflow and
    // overflow cases are both visible before clamping.
    localparam int SW = VW + 3;

    logic [2*VW-1:0]      sq_full;
    logic [2*VW-1:0]      sq_shr;
    logic [VW-1:0]        sq_sat;
    logic signed [SW-1:0] sum;

    // Quadratic term, pre-clamped to VW bits: any larger value already forces
    // the final result to saturate high, so clamping it early is exact.
    always_comb begin
        sq_full = {{VW{1'b0}}, v_i} * {{VW{1'b0}}, v_i};
        sq_shr  = sq_full >> SQ_SHIFT;
        sq_sat  = (sq_shr > {{VW{1'b0}}, {VW{1'b1}}}) ? {VW{1'b1}} : sq_shr[VW-1:0];
    end

    // Signed sum, saturation to [0, 2^VW-1], and threshold compare.
    always_comb begin
        sum      = $signed({3'b000, v_i}) + $signed({3'b000, sq_sat})
                 + $signed({3'b000, b_i}) - $signed(SW'(LEAK));
        v_next_o = VW'(sat_clamp(int'(sum), (1 << VW) - 1));
        fire_o   = (v_next_o >= V_THRESH);
    end

endmodule

// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexes one qif_update datapath across N_NEURONS virtual neurons.
// Each step request sweeps i = 0..N-1 as LOAD -> UPDATE -> WRITE, then DONE.
// Handshake: step is sampled only while busy=0 (IDLE); busy stays high from
// the first LOAD through DONE, done is high for the single DONE cycle, and
// spikes takes the new sweep's flags at the edge that leaves DONE.
// Optional feature macro: QIF_REFRACTORY_EN (per-neuron refractory counters).
module qif_neuron_scheduler
    import qif_pkg::*;
#(
    parameter int            N_NEURONS = 4,
    parameter int            VW        = QIF_VW,
    parameter logic [VW-1:0] V_THRESH  = 8'd200,
    parameter logic [VW-1:0] V_RESET   = 8'd0,
    parameter int            SQ_SHIFT  = 6,
    parameter logic [VW-1:0] LEAK      = 8'd1,
    parameter int            IW        = $clog2(N_NEURONS)
`ifdef QIF_REFRACTORY_EN
    ,
    parameter int            REFRAC    = 3
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step,
    input  logic                 cfg_we,
    input  logic [IW-1:0]        cfg_addr,
    input  logic [VW-1:0]        cfg_data,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spikes,
    output logic [VW-1:0]        v_mon,
    input  logic [IW-1:0]        mon_sel,
    output qif_state_e           dbg_state
);

    qif_state_e           state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [VW-1:0]        v_q [N_NEURONS];
    logic [VW-1:0]        b_q [N_NEURONS];
    logic [VW-1:0]        opv_q, opb_q;
    logic [VW-1:0]        vnext_q;
    logic                 fire_q;
    logic [N_NEURONS-1:0] spike_acc_q;
    logic [N_NEURONS-1:0] spikes_q;
    logic [VW-1:0]        v_mon_q;
    logic [VW-1:0]        upd_vnext;
    logic                 upd_fire;
    logic [VW-1:0]        wr_v;
    logic                 wr_spike;

`ifdef QIF_REFRACTORY_EN
    localparam int RW = $clog2(REFRAC + 1);
    logic [RW-1:0] rc_q [N_NEURONS];
    logic [RW-1:0] rc_d;
`endif

    qif_update #(
        .VW       (VW),
        .SQ_SHIFT (SQ_SHIFT),
        .V_THRESH (V_THRESH),
        .LEAK     (LEAK)
    ) u_update (
        .v_i      (opv_q),
        .b_i      (opb_q),
        .v_next_o (upd_vnext),
        .fire_o   (upd_fire)
    );

    // FSM state and neuron index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: a step outside IDLE is dropped, never queued.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (step) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD:   state_d = UPDATE;
            UPDATE: state_d = WRITE;
            WRITE: begin
                if (idx_q == IW'(N_NEURONS - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                    idx_d   = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch in LOAD and result latch in UPDATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opv_q   <= '0;
            opb_q   <= '0;
            vnext_q <= '0;
            fire_q  <= 1'b0;
        end else begin
            if (state_q == LOAD) begin
                opv_q <= v_q[idx_q];
                opb_q <= b_q[idx_q];
            end
            if (state_q == UPDATE) begin
                vnext_q <= upd_vnext;
                fire_q  <= upd_fire;
            end
        end
    end

    // Write-back value and spike flag for the neuron at idx_q.
    always_comb begin
        wr_v     = vnext_q;
        wr_spike = 1'b0;
`ifdef QIF_REFRACTORY_EN
        rc_d = rc_q[idx_q];
        if (rc_q[idx_q] != '0) begin
            wr_v = V_RESET;
            rc_d = rc_q[idx_q] - 1'b1;
        end else if (fire_q) begin
            wr_v     = V_RESET;
            wr_spike = 1'b1;
            rc_d     = RW'(REFRAC);
        end
`else
        if (fire_q) begin
            wr_v     = V_RESET;
            wr_spike = 1'b1;
        end
`endif
    end

    // Membrane array: updated only in WRITE for the current neuron.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) v_q[i] <= V_RESET;
        end else if (state_q == WRITE) begin
            v_q[idx_q] <= wr_v;
        end
    end

    // Bias array: cfg writes land in any state; out-of-range indices drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) b_q[i] <= '0;
        end else if (cfg_we && (int'(cfg_addr) < N_NEURONS)) begin
            b_q[cfg_addr] <= cfg_data;
        end
    end

`ifdef QIF_REFRACTORY_EN
    // Refractory counters: advanced once per sweep at the neuron's WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) rc_q[i] <= '0;
        end else if (state_q == WRITE) begin
            rc_q[idx_q] <= rc_d;
        end
    end
`endif

    // Spike accumulator during the sweep; published to spikes in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_acc_q <= '0;
            spikes_q    <= '0;
        end else begin
            if (state_q == WRITE) spike_acc_q[idx_q] <= wr_spike;
            if (state_q == DONE)  spikes_q <= spike_acc_q;
        end
    end

    // Registered membrane monitor; unmapped selects read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_mon_q <= '0;
        end else if (int'(mon_sel) < N_NEURONS) begin
            v_mon_q <= v_q[mon_sel];
        end else begin
            v_mon_q <= '0;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign spikes    = spikes_q;
    assign v_mon     = v_mon_q;
    assign dbg_state = state_q;

endmodule
